// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if
//   Bundles the ID/EX hazard inputs and the front-end control outputs of the
//   load-use hazard / stall-flush controller.
//   master : pipeline side, drives register specifiers and EX status, observes
//            enables, flushes and the bubble statistic.
//   slave  : hazard_stall_unit side.
//   Signals:
//     id_rs1/id_rs2, id_use_rs1/id_use_rs2 : ID source operands and use flags
//     ex_rd, ex_mem_read, ex_branch_taken  : EX destination, load flag, taken branch
//     pc_en, ifid_en                       : PC and IF/ID load enables
//     ifid_flush, idex_flush               : clear IF/ID, ID/EX to NOP
//     stall_active                         : front end held this cycle
//     bubble_count                         : saturating count of load-use bubbles
interface hazard_stall_unit_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  ex_branch_taken;
  logic                  pc_en;
  logic                  ifid_en;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic                  stall_active;
  logic [CNT_W-1:0]      bubble_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read, ex_branch_taken,
    input  pc_en, ifid_en, ifid_flush, idex_flush, stall_active, bubble_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read, ex_branch_taken,
    output pc_en, ifid_en, ifid_flush, idex_flush, stall_active, bubble_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Load-use hazard detector and stall/flush controller for the 5-stage core.
//   A load in EX whose destination (non-x0) is read by the instruction in ID
//   holds PC and IF/ID for LOAD_LATENCY cycles while ID/EX is flushed to a
//   bubble. A taken branch in EX overrides everything: it flushes IF/ID and
//   ID/EX, lets the front end advance and aborts any pending stall.
//   Ports:
//     clk   : core clock, rising edge
//     rst_n : asynchronous active-low reset; outputs take their idle values
//             immediately while it is low
//     bus   : hazard_stall_unit_if.slave (hazard inputs, control outputs)
module hazard_stall_unit #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_unit_if.slave bus
);

  typedef enum logic {IDLE, STALL} state_e;

  localparam logic [3:0] CNT_INIT = 4'(LOAD_LATENCY - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] bub_q, bub_d;

  logic rs1_hit, rs2_hit, hz;
  logic load_stall, branch_act;

  // Each use flag gates its own comparison; x0 is never a real dependency.
  assign rs1_hit = bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd);
  assign rs2_hit = bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd);
  assign hz      = bus.ex_mem_read && (bus.ex_rd != '0) && (rs1_hit || rs2_hit);

  // Outputs are qualified with rst_n so reset forces idle values at once,
  // independent of the inputs and without waiting for a clock edge.
  assign branch_act = rst_n && bus.ex_branch_taken;
  assign load_stall = rst_n && !bus.ex_branch_taken && ((state_q == STALL) || hz);

  assign bus.pc_en        = !load_stall;
  assign bus.ifid_en      = !load_stall;
  assign bus.ifid_flush   = branch_act;
  assign bus.idex_flush   = branch_act || load_stall;
  assign bus.stall_active = load_stall;
  assign bus.bubble_count = bub_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.ex_branch_taken) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == STALL) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
      end
    end else if (hz && (LOAD_LATENCY > 1)) begin
      // The hazard cycle itself is the first bubble; STALL covers the rest.
      state_d = STALL;
      cnt_d   = CNT_INIT;
    end
  end

  always_comb begin
    bub_d = bub_q;
    if (load_stall && (bub_q != '1)) begin
      bub_d = bub_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bub_q   <= bub_d;
    end
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Parametrised load-use hazard detector and pipeline stall/flush controller for the 5-stage RISC-V core.
- Replaces clock-gated bubble insertion with synchronous enables and flushes.
- Checks both source operands and ignores x0.
- Supports multi-cycle load latency through an internal stall counter.
- Handles taken-branch flush with priority over stalls.
- Sits between the ID/EX pipeline registers and the PC / IF-ID / ID-EX register enables.

Parameters:
- REG_ADDR_W, 5, width of register specifier fields.
- LOAD_LATENCY, 1, number of bubbles inserted per load-use hazard; legal range 1..15.
- CNT_W, 16, width of the saturating bubble statistics counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- id_rs1  input  REG_ADDR_W  rs1 of the instruction in ID.
- id_rs2  input  REG_ADDR_W  rs2 of the instruction in ID.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2.
- ex_rd  input  REG_ADDR_W  destination register of the instruction in EX.
- ex_mem_read  input  1  EX instruction is a load.
- ex_branch_taken  input  1  branch/jump resolved taken in EX.
- pc_en  output  1  PC register load enable.
- ifid_en  output  1  IF/ID register load enable.
- ifid_flush  output  1  clear IF/ID to NOP.
- idex_flush  output  1  clear ID/EX to NOP (bubble).
- stall_active  output  1  unit is holding the front end this cycle.
- bubble_count  output  CNT_W  number of load-use bubbles inserted since reset.

Behaviour:
- **Hazard term (combinational):**
  - hz = ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- **FSM states:** IDLE, STALL; 4-bit down-counter cnt.
- **IDLE, no hz, no branch:** pc_en = 1, ifid_en = 1, flushes = 0, stall_active = 0.
- **IDLE, hz, no branch:**
  - Same-cycle outputs: pc_en = 0, ifid_en = 0, idex_flush = 1, stall_active = 1.
  - If LOAD_LATENCY == 1: stay in IDLE.
  - Else: go to STALL with cnt = LOAD_LATENCY - 1.
- **STALL:**
  - Outputs: pc_en = 0, ifid_en = 0, idex_flush = 1, stall_active = 1.
  - hz is ignored in this state, since EX holds a bubble.
  - cnt decrements each cycle; when cnt == 1, return to IDLE next edge.
  - Total front-end hold equals exactly LOAD_LATENCY cycles.
- **ex_branch_taken (any state):** highest priority.
  - Outputs: pc_en = 1, ifid_en = 1, ifid_flush = 1, idex_flush = 1, stall_active = 0.
  - Next state IDLE, cnt cleared; any pending stall is aborted.
  - Simultaneous hz and branch: branch wins and no bubble is counted.
- **bubble_count:**
  - Increments by 1 on each edge where idex_flush is asserted due to load-use (IDLE-hz or STALL) and ex_branch_taken = 0.
  - Saturates at 2^CNT_W - 1 with no wrap.
- **Reset (rst_n low, asynchronous, also mid-stall):**
  - State = IDLE, cnt = 0, bubble_count = 0.
  - Outputs forced to pc_en = 1, ifid_en = 1, ifid_flush = 0, idex_flush = 0, stall_active = 0, regardless of inputs.
  - Normal operation resumes on the first edge after rst_n goes high.
- **Other rules:**
  - Non-load writers (ex_mem_read = 0) never stall; forwarding covers them.
  - ex_rd == 0 never stalls.
  - Operand-use qualifiers must gate each comparison independently.

Test Plan:
- LOAD_LATENCY=1; ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle -> exactly 1 cycle with pc_en=0, ifid_en=0, idex_flush=1; bubble_count 0->1.
- LOAD_LATENCY=3, rs1 match on x7 -> 3 consecutive stall cycles, then pc_en=1 while ex_mem_read=0; bubble_count=3.
- ex_rd=0 with id_rs1=0, id_use_rs1=1, load -> no stall; id_rs1 match with id_use_rs1=0 -> no stall.
- LOAD_LATENCY=3; branch_taken asserted on second stall cycle -> that cycle ifid_flush=1, idex_flush=1, pc_en=1; next cycle IDLE; bubble_count=1.
- rst_n pulled low during STALL -> outputs immediately return to the reset values, with no clock edge required; bubble_count=0.
- CNT_W=2, 5 isolated hazards -> bubble_count saturates at 3.
